// File: rtl/mips_multicycle_control_if.sv
// Control/datapath bundle for the multi-cycle MIPS controller.
// instr_retired exists only when MC_CONTROL_PERF_EN is defined.
interface mips_multicycle_control_if;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic        ext_zero;
  logic [1:0]  pc_source;
  logic        illegal_op;
  logic        mem_timeout;
  logic [3:0]  state;
`ifdef MC_CONTROL_PERF_EN
  logic [31:0] instr_retired;
`endif

  // master = controller, slave = datapath / instruction register side
  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, ext_zero, pc_source, illegal_op, mem_timeout, state
`ifdef MC_CONTROL_PERF_EN
    , output instr_retired
`endif
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, ext_zero, pc_source, illegal_op, mem_timeout, state
`ifdef MC_CONTROL_PERF_EN
    , input instr_retired
`endif
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM with memory-ready handshake, illegal-opcode trap and watchdog.
// Optional MC_CONTROL_PERF_EN adds a 32-bit retired-instruction counter.
module mips_multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mips_multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,  StDecode = 4'd1,  StMemAdr = 4'd2,  StMemRd  = 4'd3,
    StMemWb  = 4'd4,  StMemWr  = 4'd5,  StExec   = 4'd6,  StAluWb  = 4'd7,
    StBranch = 4'd8,  StJump   = 4'd9,  StJal    = 4'd10, StIExec  = 4'd11,
    StIWb    = 4'd12, StFault  = 4'd13
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLui   = 6'b001111;

  localparam logic [2:0] AluAdd   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluFunct = 3'b010;
  localparam logic [2:0] AluAnd   = 3'b011;
  localparam logic [2:0] AluOr    = 3'b100;
  localparam logic [2:0] AluXor   = 3'b101;
  localparam logic [2:0] AluSlt   = 3'b110;
  localparam logic [2:0] AluLui   = 3'b111;

  localparam logic [CNT_W-1:0] WdogLast =
      (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             run_q;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic             wdog_hit;
  logic [2:0]       imm_alu_op;
  logic             imm_ext_zero;

  // Expiry only matters while waiting; mem_ready in the same cycle takes priority.
  assign wdog_hit = (MEM_TIMEOUT != 0) && (wdog_q == WdogLast) && !bus.mem_ready;

  always_comb begin
    imm_alu_op   = AluAdd;
    imm_ext_zero = 1'b0;
    unique case (bus.opcode)
      OpSlti:  imm_alu_op = AluSlt;
      OpAndi:  begin imm_alu_op = AluAnd; imm_ext_zero = 1'b1; end
      OpOri:   begin imm_alu_op = AluOr;  imm_ext_zero = 1'b1; end
      OpXori:  begin imm_alu_op = AluXor; imm_ext_zero = 1'b1; end
      OpLui:   imm_alu_op = AluLui;
      default: imm_alu_op = AluAdd;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    if (run_q) begin
      case (state_q)
        StFetch: begin
          if (bus.mem_ready)  state_d = StDecode;
          else if (wdog_hit) begin state_d = StFault; timeout_d = 1'b1; end
        end
        StDecode: begin
          case (bus.opcode)
            OpRtype:      state_d = StExec;
            OpLw, OpSw:   state_d = StMemAdr;
            OpBeq, OpBne: state_d = StBranch;
            OpJ:          state_d = StJump;
            OpJal:        state_d = StJal;
            OpAddi, OpAddiu, OpSlti, OpAndi, OpOri, OpXori, OpLui: state_d = StIExec;
            default: begin state_d = StFault; illegal_d = 1'b1; end
          endcase
        end
        StMemAdr: state_d = (bus.opcode == OpSw) ? StMemWr : StMemRd;
        StMemRd: begin
          if (bus.mem_ready)  state_d = StMemWb;
          else if (wdog_hit) begin state_d = StFault; timeout_d = 1'b1; end
        end
        StMemWr: begin
          if (bus.mem_ready)  state_d = StFetch;
          else if (wdog_hit) begin state_d = StFault; timeout_d = 1'b1; end
        end
        StExec:   state_d = StAluWb;
        StIExec:  state_d = StIWb;
        StMemWb, StAluWb, StBranch, StJump, StJal, StIWb: state_d = StFetch;
        StFault:  state_d = StFault;
        default:  state_d = StFault;
      endcase
    end
  end

  // Counter restarts on every entry into a memory-wait state.
  always_comb begin
    wdog_d = wdog_q;
    if (run_q) begin
      if (state_d != state_q &&
          (state_d == StFetch || state_d == StMemRd || state_d == StMemWr)) begin
        wdog_d = '0;
      end else if ((state_q == StFetch || state_q == StMemRd || state_q == StMemWr) &&
                   !bus.mem_ready) begin
        wdog_d = wdog_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      run_q     <= 1'b0;
      wdog_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      wdog_q    <= wdog_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    bus.pc_write   = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_dst    = 2'b00;
    bus.mem_to_reg = 2'b00;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = AluAdd;
    bus.ext_zero   = 1'b0;
    bus.pc_source  = 2'b00;
    if (run_q) begin
      case (state_q)
        StFetch: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        StDecode: bus.alu_src_b = 2'b11;
        StMemAdr: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        StMemRd: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
        end
        StMemWb: begin
          bus.mem_to_reg = 2'b01;
          bus.reg_write  = 1'b1;
        end
        StMemWr: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
        end
        StExec: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = AluFunct;
        end
        StAluWb: begin
          bus.reg_dst   = 2'b01;
          bus.reg_write = 1'b1;
        end
        StBranch: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = AluSub;
          bus.pc_source = 2'b01;
          bus.pc_write  = (bus.opcode == OpBne) ? !bus.zero : bus.zero;
        end
        StJump: begin
          bus.pc_source = 2'b10;
          bus.pc_write  = 1'b1;
        end
        StJal: begin
          bus.reg_dst    = 2'b10;
          bus.mem_to_reg = 2'b10;
          bus.reg_write  = 1'b1;
          bus.pc_source  = 2'b10;
          bus.pc_write   = 1'b1;
        end
        StIExec: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.alu_op    = imm_alu_op;
          bus.ext_zero  = imm_ext_zero;
        end
        StIWb: begin
          bus.reg_write = 1'b1;
          bus.alu_op    = imm_alu_op;
          bus.ext_zero  = imm_ext_zero;
        end
        default: ;
      endcase
    end
  end

  assign bus.state       = state_q;
  assign bus.illegal_op  = illegal_q;
  assign bus.mem_timeout = timeout_q;

`ifdef MC_CONTROL_PERF_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (run_q && state_d == StFetch && state_q != StFetch) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign bus.instr_retired = retired_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: default instance plus a MEM_TIMEOUT=4 instance.
module tb_mips_multicycle_control;
  logic clk;
  logic rst_n;
  logic rst_n_wd;
  int   n_tests;
  int   n_fail;

  mips_multicycle_control_if bus ();
  mips_multicycle_control_if bus_wd ();

  mips_multicycle_control u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mips_multicycle_control #(
    .MEM_TIMEOUT (4),
    .CNT_W       (3)
  ) u_wd (
    .clk   (clk),
    .rst_n (rst_n_wd),
    .bus   (bus_wd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n      = 1'b0;
    rst_n_wd   = 1'b0;
    bus.opcode = 6'b000000;
    bus.zero   = 1'b0;
    bus.mem_ready    = 1'b1;
    bus_wd.opcode    = 6'b000000;
    bus_wd.zero      = 1'b0;
    bus_wd.mem_ready = 1'b0;
    #1;
    check("rst_state", 32'(bus.state), 0);
    check("rst_mem_read", 32'(bus.mem_read), 0);
    check("rst_illegal", 32'(bus.illegal_op), 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("norun_mem_read", 32'(bus.mem_read), 0);
    check("norun_pc_write", 32'(bus.pc_write), 0);

    // R-type: 0,1,6,7,0
    tick();
    check("r_fetch_state", 32'(bus.state), 0);
    check("r_fetch_mem_read", 32'(bus.mem_read), 1);
    check("r_fetch_ir_write", 32'(bus.ir_write), 1);
    check("r_fetch_pc_write", 32'(bus.pc_write), 1);
    check("r_fetch_src_b", 32'(bus.alu_src_b), 1);
    tick();
    check("r_decode_state", 32'(bus.state), 1);
    check("r_decode_src_b", 32'(bus.alu_src_b), 3);
    check("r_decode_pc_write", 32'(bus.pc_write), 0);
    tick();
    check("r_exec_state", 32'(bus.state), 6);
    check("r_exec_alu_op", 32'(bus.alu_op), 2);
    check("r_exec_src_a", 32'(bus.alu_src_a), 1);
    check("r_exec_reg_write", 32'(bus.reg_write), 0);
    tick();
    check("r_aluwb_state", 32'(bus.state), 7);
    check("r_aluwb_reg_write", 32'(bus.reg_write), 1);
    check("r_aluwb_reg_dst", 32'(bus.reg_dst), 1);
    tick();
    check("r_back_fetch", 32'(bus.state), 0);

    // lw with three wait cycles in MEMRD
    bus.opcode = 6'b100011;
    tick();
    check("lw_decode", 32'(bus.state), 1);
    tick();
    check("lw_memadr", 32'(bus.state), 2);
    check("lw_memadr_src_b", 32'(bus.alu_src_b), 2);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lw_memrd_wait", 32'(bus.state), 3);
      check("lw_memrd_read", 32'(bus.mem_read), 1);
      check("lw_memrd_iord", 32'(bus.i_or_d), 1);
    end
    tick();
    check("lw_memrd_last", 32'(bus.state), 3);
    bus.mem_ready = 1'b1;
    tick();
    check("lw_memwb", 32'(bus.state), 4);
    check("lw_memwb_m2r", 32'(bus.mem_to_reg), 1);
    check("lw_memwb_rw", 32'(bus.reg_write), 1);
    check("lw_memwb_dst", 32'(bus.reg_dst), 0);
    tick();
    check("lw_back_fetch", 32'(bus.state), 0);

    // beq taken
    bus.opcode = 6'b000100;
    bus.zero   = 1'b1;
    tick();
    tick();
    check("beq_state", 32'(bus.state), 8);
    check("beq_pc_write", 32'(bus.pc_write), 1);
    check("beq_pc_source", 32'(bus.pc_source), 1);
    check("beq_alu_op", 32'(bus.alu_op), 1);
    tick();
    check("beq_back_fetch", 32'(bus.state), 0);

    // bne with zero=1 not taken, then zero=0 taken
    bus.opcode = 6'b000101;
    tick();
    tick();
    check("bne_z1_state", 32'(bus.state), 8);
    check("bne_z1_pc_write", 32'(bus.pc_write), 0);
    bus.zero = 1'b0;
    #1;
    check("bne_z0_pc_write", 32'(bus.pc_write), 1);
    tick();
    check("bne_back_fetch", 32'(bus.state), 0);

    // jal
    bus.opcode = 6'b000011;
    tick();
    tick();
    check("jal_state", 32'(bus.state), 10);
    check("jal_reg_write", 32'(bus.reg_write), 1);
    check("jal_reg_dst", 32'(bus.reg_dst), 2);
    check("jal_m2r", 32'(bus.mem_to_reg), 2);
    check("jal_pc_write", 32'(bus.pc_write), 1);
    check("jal_pc_source", 32'(bus.pc_source), 2);
    tick();
    check("jal_back_fetch", 32'(bus.state), 0);

    // ori: zero-extended OR
    bus.opcode = 6'b001101;
    tick();
    tick();
    check("ori_iexec", 32'(bus.state), 11);
    check("ori_alu_op", 32'(bus.alu_op), 4);
    check("ori_ext_zero", 32'(bus.ext_zero), 1);
    check("ori_src_b", 32'(bus.alu_src_b), 2);
    tick();
    check("ori_iwb", 32'(bus.state), 12);
    check("ori_iwb_rw", 32'(bus.reg_write), 1);
    check("ori_iwb_alu_op", 32'(bus.alu_op), 4);
    tick();

    // slti: sign-extended SLT
    bus.opcode = 6'b001010;
    tick();
    tick();
    check("slti_alu_op", 32'(bus.alu_op), 6);
    check("slti_ext_zero", 32'(bus.ext_zero), 0);
    tick();
    tick();

    // sw, reset asserted while waiting in MEMWR
    bus.opcode = 6'b101011;
    tick();
    tick();
    check("sw_memadr", 32'(bus.state), 2);
    bus.mem_ready = 1'b0;
    tick();
    check("sw_memwr", 32'(bus.state), 5);
    check("sw_mem_write", 32'(bus.mem_write), 1);
    check("sw_iord", 32'(bus.i_or_d), 1);
    rst_n = 1'b0;
    #1;
    check("sw_rst_state", 32'(bus.state), 0);
    check("sw_rst_mem_write", 32'(bus.mem_write), 0);
    check("sw_rst_mem_read", 32'(bus.mem_read), 0);
    tick();
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    tick();

    // illegal opcode -> sticky FAULT
    bus.opcode = 6'b010000;
    tick();
    check("ill_decode", 32'(bus.state), 1);
    tick();
    check("ill_state", 32'(bus.state), 13);
    check("ill_flag", 32'(bus.illegal_op), 1);
    check("ill_mem_read", 32'(bus.mem_read), 0);
    tick();
    tick();
    check("ill_sticky_state", 32'(bus.state), 13);
    check("ill_sticky_flag", 32'(bus.illegal_op), 1);
    check("ill_no_timeout", 32'(bus.mem_timeout), 0);

    // watchdog instance: MEM_TIMEOUT=4 with mem_ready stuck low in FETCH
    rst_n_wd = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wd_waiting", 32'(bus_wd.state), 0);
    end
    check("wd_no_timeout_yet", 32'(bus_wd.mem_timeout), 0);
    tick();
    check("wd_fault_state", 32'(bus_wd.state), 13);
    check("wd_timeout_flag", 32'(bus_wd.mem_timeout), 1);
    check("wd_no_illegal", 32'(bus_wd.illegal_op), 0);
    check("wd_fault_mem_read", 32'(bus_wd.mem_read), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
